// File: rtl/des_round_fbox.sv
// DES round back-half: key mixing, S-boxes, P permutation and Feistel swap,
// in a two-stage valid/ready pipeline that sustains one item per clock.
module des_round_fbox #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [47:0]      in_exp,
   input  logic [47:0]      in_subkey,
   input  logic [31:0]      in_left,
   input  logic [31:0]      in_right,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_left,
   output logic [31:0]      out_right,
   output logic [31:0]      out_f,
   output logic [TAG_W-1:0] out_tag
);

   // One nibble per entry, indexed by {row, column}; entry 0 is the leftmost nibble.
   localparam logic [0:63][3:0] SBOX1 = {
      64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
      64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D};
   localparam logic [0:63][3:0] SBOX2 = {
      64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
      64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9};
   localparam logic [0:63][3:0] SBOX3 = {
      64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
      64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C};
   localparam logic [0:63][3:0] SBOX4 = {
      64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
      64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E};
   localparam logic [0:63][3:0] SBOX5 = {
      64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
      64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};
   localparam logic [0:63][3:0] SBOX6 = {
      64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
      64'h9EF528C3704A1DB6, 64'h432C95FABE17608D};
   localparam logic [0:63][3:0] SBOX7 = {
      64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
      64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
   localparam logic [0:63][3:0] SBOX8 = {
      64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
      64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

   // P output bit i (1-based, MSB first) takes S-box word bit P_TAB[i-1].
   localparam int P_TAB [32] = '{16,  7, 20, 21, 29, 12, 28, 17,
                                  1, 15, 23, 26,  5, 18, 31, 10,
                                  2,  8, 24, 14, 32, 27,  3,  9,
                                 19, 13, 30,  6, 22, 11,  4, 25};

   function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] g);
      logic [5:0] idx;
      idx = {g[5], g[0], g[4:1]};
      case (n)
         3'd0:    sbox = SBOX1[idx];
         3'd1:    sbox = SBOX2[idx];
         3'd2:    sbox = SBOX3[idx];
         3'd3:    sbox = SBOX4[idx];
         3'd4:    sbox = SBOX5[idx];
         3'd5:    sbox = SBOX6[idx];
         3'd6:    sbox = SBOX7[idx];
         default: sbox = SBOX8[idx];
      endcase
   endfunction

   logic             s1_valid;
   logic [47:0]      s1_x;
   logic [31:0]      s1_left;
   logic [31:0]      s1_right;
   logic [TAG_W-1:0] s1_tag;

   logic             s2_valid;
   logic [31:0]      s2_f;
   logic [31:0]      s2_left;
   logic [31:0]      s2_right;
   logic [TAG_W-1:0] s2_tag;

   logic [31:0]      sbox_word;
   logic [31:0]      f_word;
   logic             s2_adv;
   logic             in_fire;

   for (genvar j = 0; j < 8; j++) begin : g_sbox
      assign sbox_word[31-4*j -: 4] = sbox(3'(j), s1_x[47-6*j -: 6]);
   end

   for (genvar i = 0; i < 32; i++) begin : g_perm
      assign f_word[31-i] = sbox_word[32-P_TAB[i]];
   end

   assign s2_adv   = s1_valid && (!s2_valid || out_ready);
   assign in_ready = !s1_valid || s2_adv;
   assign in_fire  = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_left  <= '0;
         s1_right <= '0;
         s1_tag   <= '0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_x     <= in_exp ^ in_subkey;
         s1_left  <= in_left;
         s1_right <= in_right;
         s1_tag   <= in_tag;
      end else if (s2_adv) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_f     <= '0;
         s2_left  <= '0;
         s2_right <= '0;
         s2_tag   <= '0;
      end else if (s2_adv) begin
         s2_valid <= 1'b1;
         s2_f     <= f_word;
         s2_left  <= s1_right;
         s2_right <= s1_left ^ f_word;
         s2_tag   <= s1_tag;
      end else if (s2_valid && out_ready) begin
         s2_valid <= 1'b0;
      end
   end

   assign out_valid = s2_valid;
   assign out_f     = s2_f;
   assign out_left  = s2_left;
   assign out_right = s2_right;
   assign out_tag   = s2_tag;

endmodule

// File: tb/tb_des_round_fbox.sv
// Bench for des_round_fbox: known FIPS vectors, streaming, backpressure,
// mid-stream reset and an S-box sweep against an arithmetic DES model.
module tb_des_round_fbox;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [47:0] in_exp;
   logic [47:0] in_subkey;
   logic [31:0] in_left;
   logic [31:0] in_right;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_left;
   logic [31:0] out_right;
   logic [31:0] out_f;
   logic [3:0]  out_tag;

   des_round_fbox #(.TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_exp(in_exp), .in_subkey(in_subkey),
      .in_left(in_left), .in_right(in_right), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_left(out_left), .out_right(out_right),
      .out_f(out_f), .out_tag(out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int SB [8][64] = '{
      '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,    0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,    15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
      '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,    3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,    13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
      '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,    13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,    1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
      '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,    13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,    3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
      '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,    14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,    11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
      '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,    10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,    4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
      '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,    13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,    6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
      '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,    1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,    2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

   localparam int PT [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

   // DES bit k (1-based from the MSB) of an n-bit word is at weight 2^(n-k).
   function automatic logic [31:0] model_f(input logic [47:0] e, input logic [47:0] k);
      longint x, s, f;
      int g, row, col;
      x = longint'(e ^ k);
      s = 0;
      for (int j = 0; j < 8; j++) begin
         g   = int'((x >> (42 - 6*j)) & 63);
         row = (g / 32) * 2 + (g % 2);
         col = (g / 2) % 16;
         s   = s * 16 + longint'(SB[j][row*16 + col]);
      end
      f = 0;
      for (int i = 0; i < 32; i++)
         f = f * 2 + ((s >> (32 - PT[i])) & 1);
      return 32'(f);
   endfunction

   function automatic logic [31:0] inv_p(input logic [31:0] f);
      longint s;
      s = 0;
      for (int i = 0; i < 32; i++)
         s = s | ((longint'(f >> (31 - i)) & 1) << (32 - PT[i]));
      return 32'(s);
   endfunction

   typedef struct {
      logic [31:0] f, l, r;
      logic [3:0]  tag;
      int          acc;
   } exp_t;

   typedef struct {
      logic [47:0] e, k;
      logic [31:0] l, r;
      logic [3:0]  t;
      logic [31:0] sw, f, ol, orr;
      logic [3:0]  ot;
   } vec_t;

   exp_t        q[$];
   vec_t        vt[2];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic        lat_chk = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] pv_f, pv_l, pv_r;
   logic [3:0]  pv_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic rand_in(input logic [3:0] t);
      in_exp    = {16'($urandom), $urandom};
      in_subkey = {16'($urandom), $urandom};
      in_left   = $urandom;
      in_right  = $urandom;
      in_tag    = t;
   endtask

   // One clock: inputs are already driven; sample at the falling edge.
   task automatic step(input logic iv, input logic ordy);
      exp_t e;
      in_valid  = iv;
      out_ready = ordy;
      @(negedge clk);
      chk("in_ready", in_ready, !(q.size() == 2 && !ordy));
      if (q.size() == 0) chk("idle_out_valid", out_valid, 1'b0);
      if (prev_stall) begin
         chk("stall_valid", out_valid, 1'b1);
         chk("stall_f", out_f, pv_f);
         chk("stall_left", out_left, pv_l);
         chk("stall_right", out_right, pv_r);
         chk("stall_tag", out_tag, pv_t);
      end
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("spurious_output", 1'b1, 1'b0);
         end else begin
            e = q.pop_front();
            chk("f", out_f, e.f);
            chk("left", out_left, e.l);
            chk("right", out_right, e.r);
            chk("tag", out_tag, e.tag);
            if (lat_chk) chk("latency", 64'(cyc - e.acc), 64'd2);
         end
      end
      if (in_valid && in_ready) begin
         e.f   = model_f(in_exp, in_subkey);
         e.l   = in_right;
         e.r   = in_left ^ e.f;
         e.tag = in_tag;
         e.acc = cyc;
         q.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      pv_f = out_f; pv_l = out_left; pv_r = out_right; pv_t = out_tag;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 20) begin
         step(1'b0, 1'b1);
         n++;
      end
      chk("drain_left_items", 64'(q.size()), 64'd0);
   endtask

   initial begin
      int waited;
      vt[0] = '{48'h7A15557A1555, 48'h1B02EFFC7072, 32'hCC00CCFF, 32'hF0AAF0AA, 4'h1,
                32'h5C82B597, 32'h234AA9BB, 32'hF0AAF0AA, 32'hEF4A6544, 4'h1};
      vt[1] = '{48'h0, 48'h0, 32'h0, 32'h0, 4'h6,
                32'hEFA72C4D, 32'hD8D8DBBC, 32'h0, 32'hD8D8DBBC, 4'h6};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      rand_in(4'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_f", out_f, 32'h0);
      chk("rst_out_left", out_left, 32'h0);
      chk("rst_out_right", out_right, 32'h0);
      chk("rst_out_tag", out_tag, 4'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;

      // Known-answer vectors, one item at a time.
      for (int v = 0; v < 2; v++) begin
         in_exp = vt[v].e; in_subkey = vt[v].k;
         in_left = vt[v].l; in_right = vt[v].r; in_tag = vt[v].t;
         in_valid = 1'b1; out_ready = 1'b0;
         @(negedge clk);
         chk("kat_in_ready", in_ready, 1'b1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         rand_in(4'hF);
         waited = 0;
         for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            waited = n;
            if (out_valid) break;
         end
         chk("kat_latency", 64'(waited), 64'd2);
         chk("kat_sbox_word", inv_p(out_f), vt[v].sw);
         chk("kat_f", out_f, vt[v].f);
         chk("kat_left", out_left, vt[v].ol);
         chk("kat_right", out_right, vt[v].orr);
         chk("kat_tag", out_tag, vt[v].ot);
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         @(negedge clk);
         chk("kat_drained", out_valid, 1'b0);
         @(posedge clk); #1;
      end

      // Back-to-back streaming.
      lat_chk = 1'b1;
      for (int t = 0; t < 16; t++) begin
         rand_in(4'(t));
         step(1'b1, 1'b1);
      end
      drain();
      lat_chk = 1'b0;

      // Random backpressure with the source always offering.
      for (int n = 0; n < 300; n++) begin
         rand_in(4'($urandom));
         step(1'b1, $urandom_range(0, 99) < 30);
      end
      drain();

      // Reset with two items in flight.
      rand_in(4'hA); step(1'b1, 1'b0);
      rand_in(4'hB); step(1'b1, 1'b0);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_out_f", out_f, 32'h0);
      q.delete();
      prev_stall = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) step(1'b0, 1'b1);

      // S-box sweep: one group active at a time, zero subkey.
      lat_chk = 1'b1;
      for (int j = 0; j < 8; j++) begin
         for (int g = 0; g < 64; g++) begin
            rand_in(4'(g));
            in_subkey = 48'h0;
            in_exp    = 48'(g) << (42 - 6*j);
            step(1'b1, 1'b1);
         end
      end
      drain();
      lat_chk = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/des_round_fbox.md
# des_round_fbox

Pipelined DES round back-half: consumes the 48-bit expanded right half from the 32-to-48 expansion stage together with the round subkey and the current L/R halves. Applies key mixing, the eight DES S-boxes and the P permutation, then the Feistel swap. It emits the next-round L/R pair and the raw f-function value. Two register stages with valid/ready flow control, so rounds can be chained or iterated with full throughput and backpressure.

## Interface
- TAG_W, default 4: width of the sideband tag carried alongside each item, for example a round index or slot id.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, asynchronous assert, active-low.
- in_valid  input  1  upstream item present.
- in_ready  output  1  block accepts the item this cycle.
- in_exp  input  48  expanded right half. Bit 47 is DES bit 1.
- in_subkey  input  48  round subkey Ki. Bit 47 is DES bit 1.
- in_left  input  32  L(i-1). Bit 31 is DES bit 1.
- in_right  input  32  R(i-1), unexpanded. Bit 31 is DES bit 1.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_left  output  32  L(i) = R(i-1).
- out_right  output  32  R(i) = L(i-1) XOR f.
- out_f  output  32  f(R(i-1), Ki), after the P permutation.
- out_tag  output  TAG_W  tag of the result.

## Operation
- **Stage 1 (S1)**, on accept:
  - register x = in_exp XOR in_subkey (48 bits);
  - register in_left, in_right and in_tag;
  - set s1_valid.
- **Stage 2 (S2)**, when S1 advances:
  - split x into eight 6-bit groups; group j (j = 1..8) is x[53-6j -: 6], the MSB group first;
  - for each group, row = {b1,b6} and column = {b2..b5}, where b1 is the group MSB;
  - Sj gives a 4-bit value; concatenate S1..S8 MSB-first into s[31:0];
  - apply the standard FIPS 46-3 P table to s (P output bit 1 = s bit 16, ...) to get f;
  - register f, right (as the new L), left XOR f (as the new R) and tag; set s2_valid.
- **Outputs** come straight from the S2 registers.
  - out_valid = s2_valid.
- **Flow control**:
  - s2_adv = s1_valid && (!s2_valid || out_ready);
  - in_ready = !s1_valid || s2_adv. This is a combinational path from out_ready, which is acceptable.
  - A transfer occurs on a clock edge where valid && ready.
- **S1 update**:
  - if in_valid && in_ready, load the new item;
  - else if s2_adv, clear s1_valid.
- **S2 update**:
  - if s2_adv, load from S1;
  - else if out_valid && out_ready, clear s2_valid.
- **No bubbles**: simultaneous drain of S2 and fill from S1 sustains one item per clock.
- **No reordering and no drops.** The tag always stays paired with its data.
- **Purely arithmetic**: no internal state beyond the two pipeline registers and their valid bits. There is no state machine beyond the per-stage valid/hold logic.

## Timing
- **Reset**: rst_n low asynchronously clears s1_valid, s2_valid and all data registers.
  - out_valid = 0; out_left, out_right, out_f and out_tag all read 0.
  - in_ready = 1 from the first clock after release.
- **Latency**: an item accepted at edge N presents on out_* after edge N+1 (2-cycle latency) when unstalled.
- **Throughput**: 1 item per clock while out_ready = 1.
- **Stall**: while out_valid && !out_ready, all out_* are held bit-stable.
  - S1 may still fill once; after that in_ready = 0 until out_ready returns.
  - Capacity while stalled is 2 items.
- **Full pipeline + out_ready = 1 + in_valid = 1**: S2 drains, S1 moves to S2 and a new item enters S1, all on the same edge.
- **Empty pipeline + in_valid = 0**: valids stay 0; data registers may hold stale values, and their out_* values are don't-care while out_valid = 0.
- **Reset mid-operation**: in-flight items are discarded with no partial output. out_valid falls immediately (asynchronously).
- **Input stability**: in_* need not stay stable when in_ready = 0. Only the values present at the transfer edge are used.

## Test plan
- **FIPS round-1 vector**:
  - stimulus: in_exp = 48'h7A15557A1555, in_subkey = 48'h1B02EFFC7072, in_left = 32'hCC00CCFF, in_right = 32'hF0AAF0AA, in_tag = 4'h1;
  - required response 2 cycles later: internal S-box word 32'h5C82B597, out_f = 32'h234AA9BB, out_left = 32'hF0AAF0AA, out_right = 32'hEF4A6544, out_tag = 4'h1.
- **Zero vector**:
  - stimulus: in_exp = 0, in_subkey = 0, in_left = 0, in_right = 0;
  - required response: S-box word 32'hEFA72C4D (row 0, column 0 of S1..S8), out_f = P(32'hEFA72C4D) = 32'hD8D8DBBC, out_right = 32'hD8D8DBBC.
- **Streaming**: 16 back-to-back items with out_ready held 1 and tags 0..15 -> one result per clock from cycle 2, tags in order, each result matching the reference model.
- **Backpressure**:
  - stimulus: random out_ready at 30% duty with in_valid always 1;
  - required response: no loss or duplication; out_* stable while stalled; in_ready = 0 only when both stages are full and out_ready = 0.
- **Reset mid-stream**: rst_n pulsed low with 2 items in flight -> out_valid = 0 immediately; after release no stale item appears and in_ready = 1.
- **S-box exhaustive check**: for each j = 1..8, sweep all 64 group values with the other groups held at 0 and in_subkey = 0 -> every out_f matches the FIPS 46-3 table followed by P.
